bcd_serial_add_ctrl: RTL and testbench



---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_serial_add_ctrl_if.sv | 34 +++
 rtl/bcd_digit_add.sv | 25 ++
 rtl/bcd_serial_add_ctrl.sv | 134 +++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder sequencer.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Handshake and operand/result bundle of the serial BCD adder.
// With BCD_SUB_EN defined the bundle also carries the subtract request.
interface bcd_serial_add_ctrl_if #(parameter int DIGITS = 4);
  localparam int W = 4 * DIGITS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef BCD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  modport master (
`ifdef BCD_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
`ifdef BCD_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder; non-BCD inputs use the same +6 rule.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] t;

  always_comb begin
    t = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (t > {1'b0, BCD_MAX}) begin
      s    = t[3:0] + BCD_ADJ;
      cout = 1'b1;
    end else begin
      s    = t[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer, LSD first, one digit per clock.
// Optional macro BCD_SUB_EN adds nine's-complement subtraction (sub input).
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  bcd_serial_add_ctrl_if.slave        bus
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             state;
  state_t             state_nxt;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sr;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               busy_q;
  logic               done_q;
  logic [W-1:0]       sum_q;
  logic               cout_q;
  logic               err_q;
  logic [3:0]         ad;
  logic [3:0]         bd;
  logic [3:0]         bd_eff;
  logic [3:0]         dsum;
  logic               dcout;
  logic               last;
  logic               bad_digit;
`ifdef BCD_SUB_EN
  logic               sub_q;
`endif

  always_comb begin
    ad        = a_q[4*idx +: 4];
    bd        = b_q[4*idx +: 4];
`ifdef BCD_SUB_EN
    bd_eff    = sub_q ? (BCD_MAX - bd) : bd;
`else
    bd_eff    = bd;
`endif
    bad_digit = (ad > BCD_MAX) || (bd > BCD_MAX);
    last      = (idx == IDX_W'(DIGITS - 1));
  end

  bcd_digit_add u_digit (
    .a    (ad),
    .b    (bd_eff),
    .cin  (carry),
    .s    (dsum),
    .cout (dcout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ADD;
      ADD:     if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Control and visible result registers; sum/cout only move on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx    <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
`ifdef BCD_SUB_EN
            carry  <= bus.sub ? 1'b1 : bus.cin;
`else
            carry  <= bus.cin;
`endif
          end
        end
        ADD: begin
          carry <= dcout;
          err_q <= err_q | bad_digit;
          idx   <= last ? '0 : idx + 1'b1;
          if (last) busy_q <= 1'b0;
        end
        DONE: begin
          done_q <= 1'b1;
          sum_q  <= sr;
          cout_q <= carry;
        end
        default: ;
      endcase
    end
  end

  // Operand latches and internal shift register carry data only.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
`ifdef BCD_SUB_EN
      sub_q <= bus.sub;
`endif
    end
    if (state == ADD)
      sr <= (sr >> 4) | (W'(dsum) << (W - 4));
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed-vector bench for bcd_serial_add_ctrl (DIGITS=4), plus abort/ignore sequences.
module tb_bcd_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl_if #(.DIGITS(4)) bus ();

  bcd_serial_add_ctrl #(.DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_err;
  } vec_t;

`ifdef BCD_SUB_EN
  localparam int NV = 10;
`else
  localparam int NV = 8;
`endif

  vec_t vecs [NV];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic run_op(input vec_t v, output logic [15:0] s, output logic c,
                        output logic e, output int lat, output int bcnt);
    s = '0; c = 1'b0; e = 1'b0; lat = -1;
    @(negedge clk);
    bus.a     = v.a;
    bus.b     = v.b;
    bus.cin   = v.cin;
`ifdef BCD_SUB_EN
    bus.sub   = v.sub;
`endif
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bcnt = bus.busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k; s = bus.sum; c = bus.cout; e = bus.err;
        break;
      end
      if (bus.busy) bcnt++;
    end
  endtask

  initial begin
    logic [15:0] s;
    logic        c, e;
    int          lat, bcnt, dcnt;

    vecs[0] = '{16'h0999, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h1234, 16'h5678, 1'b1, 1'b0, 16'h6913, 1'b0, 1'b0};
    vecs[3] = '{16'h000A, 16'h0005, 1'b0, 1'b0, 16'h0015, 1'b0, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[6] = '{16'h000F, 16'h000F, 1'b1, 1'b0, 16'h0015, 1'b0, 1'b1};
    vecs[7] = '{16'h5555, 16'h4444, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
`ifdef BCD_SUB_EN
    vecs[8] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h9998, 1'b0, 1'b0};
    vecs[9] = '{16'h0100, 16'h0001, 1'b0, 1'b1, 16'h0099, 1'b1, 1'b0};
    bus.sub = 1'b0;
`endif

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_sum",  32'(bus.sum),  32'h0);
    check("rst_cout", 32'(bus.cout), 32'h0);
    check("rst_err",  32'(bus.err),  32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i], s, c, e, lat, bcnt);
      check($sformatf("v%0d_lat",  i), 32'(lat),  32'd5);
      check($sformatf("v%0d_busy", i), 32'(bcnt), 32'd4);
      check($sformatf("v%0d_sum",  i), 32'(s),    32'(vecs[i].exp_sum));
      check($sformatf("v%0d_cout", i), 32'(c),    32'(vecs[i].exp_cout));
      check($sformatf("v%0d_err",  i), 32'(e),    32'(vecs[i].exp_err));
    end

    // start held high with changing operands through ADD and DONE
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    dcnt = 0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      bus.a = 16'h9000 + 16'(k); bus.b = 16'h0999; bus.cin = 1'b1;
      @(posedge clk);
      #1;
      if (bus.done) dcnt++;
    end
    bus.start = 1'b0;
    s = bus.sum; c = bus.cout;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) dcnt++;
    end
    check("hold_done_cnt", 32'(dcnt), 32'd1);
    check("hold_sum",      32'(s),    32'h2345);
    check("hold_cout",     32'(c),    32'h0);

    // reset during the second ADD cycle aborts the operation
    @(negedge clk);
    bus.a = 16'h4321; bus.b = 16'h1111; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_sum",  32'(bus.sum),  32'h0);
    check("abort_done", 32'(bus.done), 32'h0);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    run_op(vecs[2], s, c, e, lat, bcnt);
    check("post_abort_lat",  32'(lat), 32'd5);
    check("post_abort_sum",  32'(s),   32'h6913);
    check("post_abort_cout", 32'(c),   32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
